// File: rtl/vga_sync_receiver_pkg.sv
// Shared VGA timing defaults, receiver FSM encoding and small helpers
// for the VGA sync receiver.
package vga_sync_receiver_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_LOCKED  = 2'b10
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/vga_sync_receiver_sync_edge_detect.sv
// One-bit sample register with fall/rise detection for an active-low sync line.
// Idles high so that a line already low at reset release reads as a falling edge.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  output logic fall_o,
  output logic rise_o
);

  logic sync_q;

  // Previous-sample register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 1'b1;
    end else begin
      sync_q <= sync_i;
    end
  end

  assign fall_o = sync_q & ~sync_i;
  assign rise_o = ~sync_q & sync_i;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA timing observer: recovers pixel coordinates from HS/VS, checks line and
// frame timing, and tracks lock with sticky errors and a lock-loss counter.
module vga_sync_receiver
  import vga_sync_receiver_pkg::*;
#(
  parameter int PIXEL_DISPLAY_BIT = 9,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic                       clock_25,
  input  logic                       reset,
  input  logic                       VGA_HS,
  input  logic                       VGA_VS,
  output logic [PIXEL_DISPLAY_BIT:0] rx_x,
  output logic [PIXEL_DISPLAY_BIT:0] rx_y,
  output logic                       rx_display_area,
  output logic                       rx_frame_start,
  output logic                       locked,
  output logic                       hs_error,
  output logic                       vs_error,
  output logic [7:0]                 err_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(2 * H_TOTAL + 1);
  localparam int VW      = $clog2(2 * V_TOTAL + 1);
  localparam int PW      = PIXEL_DISPLAY_BIT + 1;
  localparam int X_OFS   = H_SYNC + H_BACK;
  localparam int Y_OFS   = V_SYNC + V_BACK;

  localparam logic [HW-1:0] H_SAT    = HW'(2 * H_TOTAL);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_SYNC - 1);
  localparam logic [VW-1:0] V_SAT    = VW'(2 * V_TOTAL);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_LINES = VW'(V_SYNC);

  logic hs_fall_s, hs_rise_s, vs_fall_s, vs_rise_s;
  logic boundary_s, line_err_s, frame_err_s, err_any_s, h_win_s, v_win_s;

  logic [HW-1:0]  h_cnt_q, h_cnt_d;
  logic [VW-1:0]  v_cnt_q, v_cnt_d;
  logic [VW-1:0]  vs_lines_q, vs_lines_d;
  logic           vs_pend_q, vs_pend_d;
  rx_state_e      state_q, state_d;
  logic           acq_bad_q, acq_bad_d;
  logic           hs_err_q, hs_err_d, vs_err_q, vs_err_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic           locked_q, locked_d, fs_q, fs_d, disp_q, disp_d;
  logic [PW-1:0]  rx_x_q, rx_x_d, rx_y_q, rx_y_d;

  sync_edge_detect u_hs_edge (
    .clk_i (clock_25), .rst_ni (reset), .sync_i (VGA_HS),
    .fall_o(hs_fall_s), .rise_o(hs_rise_s)
  );

  sync_edge_detect u_vs_edge (
    .clk_i (clock_25), .rst_ni (reset), .sync_i (VGA_VS),
    .fall_o(vs_fall_s), .rise_o(vs_rise_s)
  );

  // A pending VS fall is consumed by the next HS fall, even in the same cycle.
  assign boundary_s  = hs_fall_s & (vs_pend_q | vs_fall_s);
  assign line_err_s  = (hs_fall_s && (h_cnt_q != H_LAST)) ||
                       (hs_rise_s && (h_cnt_q != HS_LAST)) ||
                       (!hs_fall_s && (h_cnt_q == H_SAT));
  assign frame_err_s = (boundary_s && (v_cnt_q != V_LAST)) ||
                       (vs_rise_s && (vs_lines_q != VS_LINES));
  assign err_any_s   = line_err_s | frame_err_s;

  // Horizontal, vertical and VS-width counters.
  always_comb begin
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    vs_lines_d = vs_lines_q;
    vs_pend_d  = vs_pend_q;
    if (hs_fall_s) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != H_SAT) begin
      h_cnt_d = h_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q;
    end
    if (boundary_s) begin
      v_cnt_d   = '0;
      vs_pend_d = 1'b0;
    end else begin
      if (hs_fall_s && (v_cnt_q != V_SAT)) begin
        v_cnt_d = v_cnt_q + 1'b1;
      end else begin
        v_cnt_d = v_cnt_q;
      end
      if (vs_fall_s) begin
        vs_pend_d = 1'b1;
      end else begin
        vs_pend_d = vs_pend_q;
      end
    end
    if (vs_fall_s) begin
      vs_lines_d = {{(VW-1){1'b0}}, hs_fall_s};
    end else if (hs_fall_s && !VGA_VS && (vs_lines_q != V_SAT)) begin
      vs_lines_d = vs_lines_q + 1'b1;
    end else begin
      vs_lines_d = vs_lines_q;
    end
  end

  // Lock FSM; an error in a boundary cycle always beats promotion.
  always_comb begin
    state_d   = state_q;
    acq_bad_d = acq_bad_q;
    hs_err_d  = hs_err_q;
    vs_err_d  = vs_err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (boundary_s) begin
          state_d   = ST_ACQUIRE;
          acq_bad_d = 1'b0;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_ACQUIRE: begin
        if (boundary_s) begin
          acq_bad_d = 1'b0;
          state_d   = (acq_bad_q || err_any_s) ? ST_ACQUIRE : ST_LOCKED;
        end else if (err_any_s) begin
          acq_bad_d = 1'b1;
        end else begin
          acq_bad_d = acq_bad_q;
        end
      end
      ST_LOCKED: begin
        if (err_any_s) begin
          hs_err_d  = hs_err_q | line_err_s;
          vs_err_d  = vs_err_q | frame_err_s;
          err_cnt_d = sat_inc8(err_cnt_q);
          state_d   = ST_SEARCH;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  assign h_win_s = (int'(h_cnt_q) >= X_OFS) && (int'(h_cnt_q) < X_OFS + H_VISIBLE);
  assign v_win_s = (int'(v_cnt_q) >= Y_OFS) && (int'(v_cnt_q) < Y_OFS + V_VISIBLE);

  // Output stage, computed from the current counters and state.
  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    fs_d     = (state_q == ST_LOCKED) && boundary_s && !err_any_s;
    disp_d   = (state_q == ST_LOCKED) && h_win_s && v_win_s;
    rx_x_d   = PW'(int'(h_cnt_q) - X_OFS);
    rx_y_d   = PW'(int'(v_cnt_q) - Y_OFS);
  end

  // State and output registers.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      vs_lines_q <= '0;
      vs_pend_q  <= 1'b0;
      state_q    <= ST_SEARCH;
      acq_bad_q  <= 1'b0;
      hs_err_q   <= 1'b0;
      vs_err_q   <= 1'b0;
      err_cnt_q  <= 8'd0;
      locked_q   <= 1'b0;
      fs_q       <= 1'b0;
      disp_q     <= 1'b0;
      rx_x_q     <= '0;
      rx_y_q     <= '0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      vs_lines_q <= vs_lines_d;
      vs_pend_q  <= vs_pend_d;
      state_q    <= state_d;
      acq_bad_q  <= acq_bad_d;
      hs_err_q   <= hs_err_d;
      vs_err_q   <= vs_err_d;
      err_cnt_q  <= err_cnt_d;
      locked_q   <= locked_d;
      fs_q       <= fs_d;
      disp_q     <= disp_d;
      rx_x_q     <= rx_x_d;
      rx_y_q     <= rx_y_d;
    end
  end

  assign rx_x            = rx_x_q;
  assign rx_y            = rx_y_q;
  assign rx_display_area = disp_q;
  assign rx_frame_start  = fs_q;
  assign locked          = locked_q;
  assign hs_error        = hs_err_q;
  assign vs_error        = vs_err_q;
  assign err_count       = err_cnt_q;

endmodule
